gf163_digit_serializer: RTL

//  Upstream feeder of the D8 systolic GF(2^163) multiplier. Accepts one 163-bit

---
 rtl/gf163_pkg.sv | 24 ++
 rtl/gf163_op_hold.sv | 32 +++
 rtl/gf163_digit_serializer.sv | 104 ++++++++++
 3 files changed

// File: rtl/gf163_pkg.sv
// Shared constants and FSM state type for the GF(2^163) digit serializer slice.
// Operand width, digit width, digit count and padding are all derived here.
package gf163_pkg;

    localparam int M      = 163;
    localparam int D      = 8;
    localparam int NDIG   = (M + D - 1) / D;
    localparam int CNT_W  = 5;
    localparam int SREG_W = NDIG * D;
    localparam int PAD_W  = SREG_W - M;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Zero-pad an operand to a whole number of digits, padding on the MS side.
    function automatic logic [SREG_W-1:0] pad_op(input logic [M-1:0] op);
        return {{PAD_W{1'b0}}, op};
    endfunction

endpackage

// File: rtl/gf163_op_hold.sv
// One-deep operand holding register with a valid flag, used to prefetch the
// next operand while the current one is still being serialized.
module gf163_op_hold
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [M-1:0] wr_data,
    input  logic         clr,
    output logic [M-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while valid is set.
    always_ff @(posedge clk) begin
        if (wr) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/gf163_digit_serializer.sv
// Feeds a 163-bit operand into the D8 systolic multiplier as 21 MSB-first digits.
// Define SER_PREFETCH_EN to add a hold register so operands stream with no bubble.
module gf163_digit_serializer
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] op_in,
    input  logic         op_valid,
    output logic         op_ready,
    output logic [D-1:0] dig_out,
    output logic         dig_valid,
    output logic         dig_first,
    output logic         dig_last,
    output logic         busy
);

    // Handshake: an operand transfers on a rising edge where op_valid && op_ready.
    // op_ready is a function of internal state and rst only, never of op_valid.
    // The digit side has no ready: the array takes one digit every cycle.

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [SREG_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic              at_last;
    logic              handshake;
    logic              load;
    logic [M-1:0]      load_op;

    assign at_last = (state == SHIFT) && (cnt == LAST_CNT);

`ifdef SER_PREFETCH_EN
    logic         hold_valid;
    logic [M-1:0] hold_data;
    logic         load_window;
    logic         hold_wr;
    logic         hold_clr;

    assign op_ready    = !rst && !hold_valid;
    assign handshake   = op_valid && op_ready;
    assign load_window = (state == IDLE) || at_last;
    assign load        = load_window && (hold_valid || handshake);
    assign load_op     = hold_valid ? hold_data : op_in;
    // An accepted operand that cannot start this cycle parks in the hold register.
    assign hold_wr     = handshake && !load_window;
    assign hold_clr    = load && hold_valid;

    gf163_op_hold u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr      (hold_wr),
        .wr_data (op_in),
        .clr     (hold_clr),
        .data    (hold_data),
        .valid   (hold_valid)
    );
`else
    assign op_ready  = !rst && (state == IDLE);
    assign handshake = op_valid && op_ready;
    assign load      = handshake;
    assign load_op   = op_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (at_last && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every load, so it never runs past the last digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= pad_op(load_op);
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sreg <= {sreg[SREG_W-D-1:0], {D{1'b0}}};
            cnt  <= at_last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        dig_valid = (state == SHIFT);
        busy      = (state == SHIFT);
        dig_out   = dig_valid ? sreg[SREG_W-1 -: D] : '0;
        dig_first = dig_valid && (cnt == '0);
        dig_last  = at_last;
    end

endmodule
